// File: rtl/ecap5_dproc_pkg.sv
// Shared definitions for the interrupt controller: register map, CLAIM word layout and the
// Wishbone byte-lane helper.
package ecap5_dproc_pkg;

  // Register select, decoded from wb_adr_i[3:2] (byte offsets 0x0, 0x4, 0x8, 0xC).
  typedef enum logic [1:0] {
    RegPending = 2'h0,
    RegEnable  = 2'h1,
    RegEdge    = 2'h2,
    RegClaim   = 2'h3
  } irq_reg_e;

  localparam int unsigned ClaimValidBit = 31;
  localparam int unsigned ClaimIdWidth  = 5;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Wishbone B4 pipelined bus between a master and the interrupt controller.
interface irq_ctrl_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_stall_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_stall_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_stall_o
  );
endinterface

// File: rtl/irq_sync.sv
// Two-flop synchronizer for one asynchronous interrupt line, plus a delayed copy so a
// synchronized rising edge can be detected.
module irq_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= src_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~dly_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source enable/edge configuration, pending tracking, lowest-index
// CLAIM with auto-clear for edge sources, and a registered request to the core.
module irq_ctrl
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned NB_SOURCES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NB_SOURCES-1:0] irq_src_i,
  output logic                  irq_o,
  irq_ctrl_if.slave             wb
);

  logic [NB_SOURCES-1:0] level, rise;
  logic [NB_SOURCES-1:0] pend_q, pend_d, en_q, en_d, edge_mode_q, edge_mode_d;
  logic [NB_SOURCES-1:0] w1c, claim_clr;
  logic                  req, wr, rd, claim_rd, claim_valid;
  logic [ClaimIdWidth-1:0] claim_id;
  irq_reg_e              reg_sel;
  logic [31:0]           mask, rdata, dat_q;
  logic                  ack_q, irq_q;
  logic                  unused_adr;

  for (genvar i = 0; i < NB_SOURCES; i++) begin : g_sync
    irq_sync u_sync (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .src_i   (irq_src_i[i]),
      .level_o (level[i]),
      .rise_o  (rise[i])
    );
  end

  assign req        = wb.wb_cyc_i & wb.wb_stb_i;
  assign wr         = req & wb.wb_we_i;
  assign rd         = req & ~wb.wb_we_i;
  assign reg_sel    = irq_reg_e'(wb.wb_adr_i[3:2]);
  assign mask       = lane_mask(wb.wb_sel_i);
  assign unused_adr = ^{wb.wb_adr_i[31:4], wb.wb_adr_i[1:0]};

  // Lowest enabled pending index wins; scan downward so the last hit is the lowest.
  always_comb begin
    claim_valid = 1'b0;
    claim_id    = '0;
    for (int i = int'(NB_SOURCES) - 1; i >= 0; i--) begin
      if (pend_q[i] & en_q[i]) begin
        claim_valid = 1'b1;
        claim_id    = ClaimIdWidth'(i);
      end
    end
  end

  assign claim_rd = rd & (reg_sel == RegClaim) & claim_valid;

  always_comb begin
    en_d        = en_q;
    edge_mode_d = edge_mode_q;
    w1c         = '0;
    claim_clr   = '0;
    if (wr) begin
      unique case (reg_sel)
        RegPending: w1c = NB_SOURCES'(wb.wb_dat_i & mask);
        RegEnable:  en_d = NB_SOURCES'((32'(en_q) & ~mask) | (wb.wb_dat_i & mask));
        RegEdge:    edge_mode_d = NB_SOURCES'((32'(edge_mode_q) & ~mask) | (wb.wb_dat_i & mask));
        RegClaim:   ;
      endcase
    end
    for (int i = 0; i < int'(NB_SOURCES); i++) begin
      claim_clr[i] = claim_rd & (claim_id == ClaimIdWidth'(i));
    end
    // A new edge wins over any clear landing in the same cycle; level sources ignore clears.
    pend_d = (edge_mode_q & ((pend_q & ~(w1c | claim_clr)) | rise)) | (~edge_mode_q & level);
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      RegPending: rdata = 32'(pend_q);
      RegEnable:  rdata = 32'(en_q);
      RegEdge:    rdata = 32'(edge_mode_q);
      RegClaim: begin
        rdata[ClaimValidBit]       = claim_valid;
        rdata[ClaimIdWidth-1:0]    = claim_id;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q      <= '0;
      en_q        <= '0;
      edge_mode_q <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      irq_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      en_q        <= en_d;
      edge_mode_q <= edge_mode_d;
      ack_q       <= req;
      dat_q       <= rd ? rdata : '0;
      irq_q       <= |(pend_q & en_q);
    end
  end

  assign irq_o         = irq_q;
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_dat_o   = dat_q;
  assign wb.wb_stall_o = 1'b0;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the register rules.
module tb_irq_ctrl;
  import ecap5_dproc_pkg::*;

  localparam int unsigned NB      = 16;
  localparam logic [31:0] SrcMask = 32'h0000_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] irq_src;
  logic          irq;

  irq_ctrl_if bus ();

  irq_ctrl #(.NB_SOURCES(NB)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .irq_src_i (irq_src),
    .irq_o     (irq),
    .wb        (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] m_pend, m_en, m_edge;
  logic [31:0] hist[$];   // past input samples, newest first
  logic [31:0] src_val;
  logic [31:0] obs_dat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] claim_word(input logic [31:0] pe);
    for (int i = 0; i < 32; i++) begin
      if (pe[i]) return 32'h8000_0000 | 32'(i);
    end
    return 32'h0;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    m = 32'h0;
    if (sel[0]) m = m | 32'h0000_00FF;
    if (sel[1]) m = m | 32'h0000_FF00;
    if (sel[2]) m = m | 32'h00FF_0000;
    if (sel[3]) m = m | 32'hFF00_0000;
    return m;
  endfunction

  task automatic model_reset();
    m_pend = 32'h0;
    m_en   = 32'h0;
    m_edge = 32'h0;
    hist   = '{32'h0, 32'h0, 32'h0};
  endtask

  // One clock cycle: drive, predict from the pre-edge model state, advance, compare.
  task automatic tick(input logic cyc, input logic stb, input logic we, input logic [31:0] adr,
                      input logic [31:0] wdat, input logic [3:0] sel);
    logic [31:0] pe, rval, exp_dat, lvl, rise, clr, mask, cw, np;
    logic        exp_ack, exp_irq, req;
    irq_src       = src_val[NB-1:0];
    bus.wb_cyc_i  = cyc;
    bus.wb_stb_i  = stb;
    bus.wb_we_i   = we;
    bus.wb_adr_i  = adr;
    bus.wb_dat_i  = wdat;
    bus.wb_sel_i  = sel;
    req  = cyc & stb;
    pe   = m_pend & m_en;
    cw   = claim_word(pe);
    case (adr[3:2])
      2'd0:    rval = m_pend;
      2'd1:    rval = m_en;
      2'd2:    rval = m_edge;
      default: rval = cw;
    endcase
    exp_ack = req;
    exp_dat = (req && !we) ? rval : 32'h0;
    exp_irq = (pe != 32'h0);
    mask = byte_mask(sel);
    // Synchronized level is the sample two edges old; a rise compares it with the one before.
    lvl  = hist[1];
    rise = hist[1] & ~hist[2];
    clr  = 32'h0;
    if (req && we && adr[3:2] == 2'd0) clr = wdat & mask;
    if (req && !we && adr[3:2] == 2'd3 && pe != 32'h0) clr = clr | (32'h1 << cw[4:0]);
    np = 32'h0;
    for (int i = 0; i < int'(NB); i++) begin
      if (m_edge[i]) np[i] = (m_pend[i] & ~clr[i]) | rise[i];
      else           np[i] = lvl[i];
    end
    @(posedge clk);
    #1;
    m_pend = np;
    if (req && we && adr[3:2] == 2'd1) m_en   = ((m_en & ~mask) | (wdat & mask)) & SrcMask;
    if (req && we && adr[3:2] == 2'd2) m_edge = ((m_edge & ~mask) | (wdat & mask)) & SrcMask;
    hist.push_front(src_val & SrcMask);
    void'(hist.pop_back());
    check("ack", 32'(bus.wb_ack_o), 32'(exp_ack));
    check("dat", bus.wb_dat_o, exp_dat);
    check("irq", 32'(irq), 32'(exp_irq));
    check("stall", 32'(bus.wb_stall_o), 32'h0);
    obs_dat = bus.wb_dat_o;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rd(input logic [31:0] adr);
    tick(1'b1, 1'b1, 1'b0, adr, 32'h0, 4'hF);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    tick(1'b1, 1'b1, 1'b1, adr, dat, sel);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    src_val      = 32'h0;
    irq_src      = '0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'h0;
    bus.wb_dat_i = 32'h0;
    bus.wb_sel_i = 4'h0;
    #1;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ack", 32'(bus.wb_ack_o), 32'h0);
    check("rst_dat", bus.wb_dat_o, 32'h0);
    check("rst_stall", 32'(bus.wb_stall_o), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    do_reset();
    rd(32'h0); check("reset_pend", obs_dat, 32'h0);
    rd(32'h4); check("reset_en", obs_dat, 32'h0);
    rd(32'h8); check("reset_edge", obs_dat, 32'h0);
    rd(32'hC); check("reset_claim", obs_dat, 32'h0);

    // Edge latency and claim of an edge source.
    wr(32'h8, 32'h1, 4'hF);
    wr(32'h4, 32'h1, 4'hF);
    src_val = 32'h1;
    idle(1); check("edge_irq_k", 32'(irq), 32'h0);
    src_val = 32'h0;
    idle(1);
    rd(32'h0); check("edge_pend_k1", obs_dat, 32'h0); check("edge_irq_k2", 32'(irq), 32'h0);
    rd(32'h0); check("edge_pend_k2", obs_dat, 32'h1); check("edge_irq_k3", 32'(irq), 32'h1);
    rd(32'hC); check("edge_claim", obs_dat, 32'h8000_0000);
    idle(2); check("edge_irq_cleared", 32'(irq), 32'h0);

    // Level source: claims do not clear, release drops irq three cycles later.
    do_reset();
    wr(32'h8, 32'h0, 4'hF);
    wr(32'h4, 32'h8, 4'hF);
    src_val = 32'h8;
    idle(3);
    for (int i = 0; i < 3; i++) begin
      rd(32'hC); check("level_claim", obs_dat, 32'h8000_0003);
    end
    src_val = 32'h0;
    idle(1); check("level_irq_k", 32'(irq), 32'h1);
    idle(2); check("level_irq_k2", 32'(irq), 32'h1);
    idle(1); check("level_irq_k3", 32'(irq), 32'h0);

    // Priority between two edge sources.
    do_reset();
    wr(32'h8, 32'h24, 4'hF);
    wr(32'h4, 32'h24, 4'hF);
    src_val = 32'h24;
    idle(1);
    src_val = 32'h0;
    idle(3);
    rd(32'hC); check("prio_first", obs_dat, 32'h8000_0002);
    rd(32'hC); check("prio_second", obs_dat, 32'h8000_0005);
    rd(32'hC); check("prio_third", obs_dat, 32'h0);

    // A new edge coinciding with a W1C keeps the bit set.
    do_reset();
    wr(32'h8, 32'h1, 4'hF);
    wr(32'h4, 32'h1, 4'hF);
    src_val = 32'h1; idle(1);
    src_val = 32'h0; idle(3);
    rd(32'h0); check("sc_pend_before", obs_dat, 32'h1);
    src_val = 32'h1; idle(1);
    src_val = 32'h0; idle(1);
    wr(32'h0, 32'h1, 4'hF);
    rd(32'h0); check("sc_set_wins", obs_dat, 32'h1);
    wr(32'h0, 32'h1, 4'hF);
    rd(32'h0); check("sc_w1c_alone", obs_dat, 32'h0);

    // Back-to-back reads and byte-lane writes.
    do_reset();
    wr(32'h4, 32'hA5, 4'hF);
    wr(32'h8, 32'h300, 4'hF);
    rd(32'h0); check("b2b_ack0", 32'(bus.wb_ack_o), 32'h1); check("b2b_d0", obs_dat, 32'h0);
    rd(32'h4); check("b2b_ack1", 32'(bus.wb_ack_o), 32'h1); check("b2b_d1", obs_dat, 32'hA5);
    rd(32'h8); check("b2b_ack2", 32'(bus.wb_ack_o), 32'h1); check("b2b_d2", obs_dat, 32'h300);
    rd(32'hC); check("b2b_ack3", 32'(bus.wb_ack_o), 32'h1); check("b2b_d3", obs_dat, 32'h0);
    idle(1); check("b2b_ack_end", 32'(bus.wb_ack_o), 32'h0);
    wr(32'h4, 32'hFFFF, 4'b0001);
    rd(32'h4); check("lane_en", obs_dat, 32'h00FF);

    // Reset just after a read is accepted.
    do_reset();
    wr(32'h4, 32'hFF, 4'hF);
    wr(32'h8, 32'h0F, 4'hF);
    src_val = 32'h1; idle(1);
    src_val = 32'h0; idle(3);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 32'h4;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_ack", 32'(bus.wb_ack_o), 32'h0);
    do_reset();
    idle(2); check("midrst_no_ack", 32'(bus.wb_ack_o), 32'h0);
    rd(32'h0); check("midrst_pend", obs_dat, 32'h0);
    rd(32'h4); check("midrst_en", obs_dat, 32'h0);
    rd(32'h8); check("midrst_edge", obs_dat, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);

    // Randomized traffic against the model, including aliased addresses and dropped cycles.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic c, s, w;
      if ($urandom_range(0, 3) == 0) src_val = $urandom & SrcMask;
      c = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 9) < 8);
      w = ($urandom_range(0, 2) == 0);
      tick(c, s, w, $urandom, $urandom, 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NB_SOURCES, default 16, giving the number of interrupt sources (legal range 1..31).
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port irq_src_i, input, NB_SOURCES bits: asynchronous interrupt request lines.
REQ-005 SHALL have port irq_o, output, 1 bit: registered request to the processor core irq_i.
REQ-006 SHALL have Wishbone B4 pipelined slave ports:
- wb_adr_i, input, 32: byte address.
- wb_dat_i, input, 32: write data.
- wb_dat_o, output, 32: read data.
- wb_sel_i, input, 4: byte lanes.
- wb_we_i, input, 1: write enable.
- wb_stb_i, input, 1: strobe.
- wb_cyc_i, input, 1: cycle.
- wb_ack_o, output, 1: acknowledge.
- wb_stall_o, output, 1: stall.

Function
REQ-007 SHALL pass each irq_src_i bit through a 2-flop synchronizer, then a 1-flop delayed copy for edge detection.
REQ-008 SHALL hold registers ENABLE, EDGE and PENDING, each NB_SOURCES bits; bits at index >= NB_SOURCES SHALL read 0.
REQ-009 SHALL, for an edge source (EDGE=1), set PENDING on a synchronized 0->1 transition; the bit stays set until cleared.
REQ-010 SHALL, for a level source (EDGE=0), load PENDING every cycle with the synchronized level; clears have no effect.
REQ-011 SHALL decode the register map on wb_adr_i[3:2], ignoring the other address bits:
- 0x0 PENDING: read; write-1-to-clear.
- 0x4 ENABLE: read/write.
- 0x8 EDGE: read/write.
- 0xC CLAIM: read-only; writes are ignored but acknowledged.
REQ-012 SHALL, on a CLAIM read, return {bit31 = valid, bits4:0 = lowest index i with PENDING[i]&ENABLE[i], others 0}; the value is 0 when there is no such index.
REQ-013 SHALL, on a valid CLAIM read of an edge source, clear that source's PENDING bit in the same cycle the request is accepted.
REQ-014 SHALL apply writes per byte lane according to wb_sel_i; an unselected lane keeps its value.
REQ-015 SHALL accept a request when wb_cyc_i&wb_stb_i; wb_stall_o is constantly 0.
REQ-016 SHALL assert wb_ack_o for exactly one cycle, one cycle after acceptance, with wb_dat_o registered alongside it.
REQ-017 SHALL sustain back-to-back requests at one per cycle, giving one ack per request in order.
REQ-018 SHALL drive wb_dat_o = 0 whenever wb_ack_o is 0.
REQ-019 SHALL register irq_o = |(PENDING & ENABLE).
REQ-020 SHALL meet this latency: irq_src_i first sampled high at edge k gives PENDING set at edge k+2 and irq_o high at edge k+3.
REQ-021 SHALL resolve simultaneous events as follows:
- A set and a W1C clear or claim-clear on the same bit in the same cycle leave PENDING = 1.
- An ENABLE write and the irq_o update in the same cycle use the pre-write ENABLE.
REQ-022 SHALL treat wb_cyc_i dropping mid-burst as abandoning the burst: pending acks are suppressed from the next cycle.

Reset
REQ-023 SHALL, while rst_i is high, asynchronously clear the synchronizers, edge flops, PENDING, ENABLE and EDGE.
REQ-024 SHALL hold outputs at irq_o=0, wb_ack_o=0, wb_dat_o=0 and wb_stall_o=0 while rst_i is high.
REQ-025 SHALL discard any in-flight request when reset occurs mid-transaction; no ack is issued after reset release.

Structure
REQ-026 SHALL place register offsets, CLAIM valid-bit position and the ID field width in the shared package ecap5_dproc_pkg.
REQ-027 SHALL implement the synchronizer plus edge detector as sub-module irq_sync, instantiated once per source.
REQ-028 SHALL compute the CLAIM priority encoder combinationally within irq_ctrl.

Verification
REQ-029 SHALL verify edge latency: with EDGE=0x1 and ENABLE=0x1, pulse irq_src_i[0] -> PENDING=0x1 at k+2, irq_o=1 at k+3; a CLAIM read returns 0x80000000; irq_o=0 two cycles after the ack.
REQ-030 SHALL verify level behaviour: with EDGE=0, ENABLE=0x8, hold irq_src_i[3]=1 -> CLAIM returns 0x80000003 repeatedly; release the input -> irq_o=0 three cycles later.
REQ-031 SHALL verify priority: edges on sources 5 and 2 with ENABLE=0x24 -> first CLAIM returns 0x80000002, second 0x80000005, third 0x00000000.
REQ-032 SHALL verify set-versus-clear: a W1C of PENDING=0x1 coinciding with a new edge on source 0 -> PENDING reads 0x1 afterwards.
REQ-033 SHALL verify pipelining and lanes: 4 back-to-back reads at 0x0/0x4/0x8/0xC -> 4 consecutive acks in order, wb_stall_o=0; a write of 0xFFFF to ENABLE with wb_sel_i=4'b0001 -> ENABLE reads 0x00FF.
REQ-034 SHALL verify reset mid-operation: assert rst_i one cycle after a read is accepted -> no ack; all registers read 0 afterwards; irq_o=0.
